spi_mstr_ctrl: RTL and testbench

SPI master controller that sequences single-word transfers on the four-wire SPI bus (sclk, ss_n, mosi, miso). It accepts a word from a ready/valid transmit port, frames it with ss_n, generates sclk at a programmable rate in any of the four CPOL/CPHA modes, shifts MSB-first, and returns the captured miso word on a one-cycle receive strobe. It sits between the host-side register/sequencer logic and the pins that drive the SPI interface's master modport.

---
 rtl/spi_mstr_ctrl_pkg.sv | 24 ++
 rtl/spi_mstr_ctrl_if.sv | 12 +
 rtl/spi_mstr_ctrl_clk_div.sv | 32 +++
 rtl/spi_mstr_ctrl.sv | 143 ++++++++++++++
 tb/tb_spi_mstr_ctrl.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/spi_mstr_ctrl_pkg.sv
// Shared types for the SPI master controller.
//   spi_state_t : word-sequencing FSM states
//   spi_mode_t  : latched CPOL/CPHA pair for the word in flight
//   edge_cnt_w  : width of the half-period counter (counts 0..2*data_w)
package spi_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        XFER,
        TRAIL,
        GAP
    } spi_state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    function automatic int edge_cnt_w(input int data_w);
        return $clog2(2 * data_w + 1);
    endfunction

endpackage

// File: rtl/spi_mstr_ctrl_if.sv
// Four-wire SPI bus.
//   master : drives sclk, ss_n, mosi; receives miso
//   slave  : receives sclk, ss_n, mosi; drives miso
interface spi_mstr_ctrl_if;
    logic sclk;
    logic ss_n;
    logic mosi;
    logic miso;

    modport master (output sclk, output ss_n, output mosi, input miso);
    modport slave  (input sclk, input ss_n, input mosi, output miso);
endinterface

// File: rtl/spi_mstr_ctrl_clk_div.sv
// Loadable half-period down-counter.
//   load  : restart an interval from div (div+1 cycles long)
//   en    : count while high
//   div   : half-period minus one
//   tick  : last cycle of the current interval (counter reloads itself)
//   start : first cycle of the current interval
module spi_clk_div #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick,
    output logic             start
);
    logic [DIV_W-1:0] cnt;

    assign tick  = en && (cnt == '0);
    // Counter sits at div right after every (re)load.
    assign start = (cnt == div);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (load || tick)
            cnt <= div;
        else if (en)
            cnt <= cnt - DIV_W'(1);
    end
endmodule

// File: rtl/spi_mstr_ctrl.sv
// SPI master: sends one DATA_W word per ss_n frame, MSB first, any CPOL/CPHA.
//   cfg_div/cfg_cpol/cfg_cpha : rate and mode, latched when a word is accepted
//   tx_valid/tx_ready/tx_data : transmit handshake (ready only in IDLE)
//   rx_valid/rx_data          : one-cycle strobe with the captured miso word
//   busy                      : high outside IDLE
//   spi                       : SPI bus, master side (all outputs registered)
module spi_mstr_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic              cfg_cpol,
    input  logic              cfg_cpha,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [DATA_W-1:0] tx_data,
    output logic              rx_valid,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    spi_mstr_ctrl_if.master   spi
);
    localparam int            EW      = edge_cnt_w(DATA_W);
    localparam logic [EW-1:0] LAST_HP = EW'(2 * DATA_W);
    localparam logic [EW-1:0] PREV_HP = EW'(2 * DATA_W - 1);

    spi_state_t        state, state_nxt;
    spi_mode_t         mode_q;
    logic [DIV_W-1:0]  div_q, div_ld;
    logic [EW-1:0]     hp;       // current half-period k, 1..2*DATA_W
    logic [DATA_W-1:0] sh_tx;    // bits still to be driven, next one at MSB
    logic [DATA_W-1:0] sh_rx;
    logic              sclk_q, ss_n_q, mosi_q;
    logic              tick, hp_start, accept, last_hp, sample, advance;

    assign busy     = (state != IDLE);
    assign accept   = tx_valid && tx_ready;
    assign last_hp  = (hp == LAST_HP);
    // Odd k is the leading edge: CPHA=0 samples there, CPHA=1 on even k.
    assign sample   = hp_start && (hp[0] ^ mode_q.cpha);
    // Decided on the current k for the edge entering k+1.
    assign advance  = mode_q.cpha ? ~hp[0] : (hp[0] && (hp != PREV_HP));
    // The divider loads straight from the config port on acceptance.
    assign div_ld   = (state == IDLE) ? cfg_div : div_q;

    assign spi.sclk = sclk_q;
    assign spi.ss_n = ss_n_q;
    assign spi.mosi = mosi_q;

    spi_clk_div #(.DIV_W(DIV_W)) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .en    (busy),
        .div   (div_ld),
        .tick  (tick),
        .start (hp_start)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)           state_nxt = LEAD;
            LEAD:    if (tick)             state_nxt = XFER;
            XFER:    if (tick && last_hp)  state_nxt = TRAIL;
            TRAIL:   if (tick)             state_nxt = GAP;
            GAP:     if (tick)             state_nxt = IDLE;
            default:                       state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_ready <= 1'b0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
            sclk_q   <= 1'b0;
            ss_n_q   <= 1'b1;
            mosi_q   <= 1'b0;
            mode_q   <= '0;
            div_q    <= '0;
            hp       <= '0;
            sh_tx    <= '0;
            sh_rx    <= '0;
        end else begin
            tx_ready <= (state_nxt == IDLE);
            rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    sclk_q <= cfg_cpol;
                    ss_n_q <= 1'b1;
                    mosi_q <= 1'b0;
                    if (accept) begin
                        mode_q <= '{cpol: cfg_cpol, cpha: cfg_cpha};
                        div_q  <= cfg_div;
                        ss_n_q <= 1'b0;
                        mosi_q <= tx_data[DATA_W-1];
                        sh_tx  <= {tx_data[DATA_W-2:0], 1'b0};
                    end
                end
                LEAD: begin
                    if (tick) begin
                        hp     <= EW'(1);
                        sclk_q <= ~mode_q.cpol;
                    end
                end
                XFER: begin
                    if (sample)
                        sh_rx <= {sh_rx[DATA_W-2:0], spi.miso};
                    if (tick) begin
                        if (last_hp) begin
                            sclk_q <= mode_q.cpol;
                        end else begin
                            hp     <= hp + EW'(1);
                            sclk_q <= mode_q.cpol ^ ~hp[0];
                            if (advance) begin
                                mosi_q <= sh_tx[DATA_W-1];
                                sh_tx  <= {sh_tx[DATA_W-2:0], 1'b0};
                            end
                        end
                    end
                end
                TRAIL: begin
                    if (tick) begin
                        ss_n_q   <= 1'b1;
                        mosi_q   <= 1'b0;
                        rx_valid <= 1'b1;
                        rx_data  <= sh_rx;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_mstr_ctrl.sv
// Directed bench for spi_mstr_ctrl: a table of single-word transfers checked
// for data and cycle timing against a behavioural SPI slave, plus hand-written
// sequences for reset, back-to-back words and mid-transfer reset.
module tb_spi_mstr_ctrl;
    localparam int DATA_W = 8;
    localparam int DIV_W  = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [DIV_W-1:0]  cfg_div = '0;
    logic              cfg_cpol = 1'b0, cfg_cpha = 1'b0, tx_valid = 1'b0;
    logic [DATA_W-1:0] tx_data = '0;
    logic              tx_ready, rx_valid, busy;
    logic [DATA_W-1:0] rx_data;

    spi_mstr_ctrl_if spi_bus ();

    spi_mstr_ctrl #(.DATA_W(DATA_W), .DIV_W(DIV_W)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_div(cfg_div), .cfg_cpol(cfg_cpol),
        .cfg_cpha(cfg_cpha), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_data(tx_data), .rx_valid(rx_valid), .rx_data(rx_data),
        .busy(busy), .spi(spi_bus)
    );

    always #5 clk = ~clk;

    // Behavioural slave: launches on the non-sampling edge, records mosi on
    // the sampling edge, counts every sclk edge inside the frame.
    logic [7:0] s_tx = '0, s_rx = '0;
    logic       s_cpol = 1'b0, s_cpha = 1'b0, s_miso = 1'b0, loop_en = 1'b0;
    logic       prev_ss = 1'b1, prev_sclk = 1'b0;
    int         s_idx = 0, s_edges = 0;

    assign spi_bus.miso = loop_en ? spi_bus.mosi : s_miso;

    always @(spi_bus.ss_n or spi_bus.sclk) begin
        if (prev_ss && !spi_bus.ss_n) begin
            s_rx    = '0;
            s_edges = 0;
            s_idx   = 7;
            if (!s_cpha) begin
                s_miso = s_tx[s_idx];
                s_idx  = s_idx - 1;
            end
        end else if (!spi_bus.ss_n && (spi_bus.sclk != prev_sclk)) begin
            s_edges = s_edges + 1;
            if ((spi_bus.sclk != s_cpol) ^ s_cpha) begin
                s_rx = {s_rx[6:0], spi_bus.mosi};
            end else if (s_idx >= 0) begin
                s_miso = s_tx[s_idx];
                s_idx  = s_idx - 1;
            end
        end
        prev_ss   = spi_bus.ss_n;
        prev_sclk = spi_bus.sclk;
    end

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    typedef struct {
        logic       cpol, cpha;
        logic [7:0] div, tx, slv;
        bit         loop, chg;
        logic       chg_cpol, chg_cpha;
        logic [7:0] chg_div;
        logic [7:0] exp_rx;
        int         exp_rx_cyc, exp_rdy_cyc;
    } vec_t;

    // Accept at cycle 0; count cycles on the following negedges.
    task automatic run_word(input vec_t v, input int id);
        string t;
        int first_low, last_low, nrx, rx_cyc, rdy_cyc;
        logic [7:0] rx_val;
        logic busy_mid;
        t = $sformatf("v%0d_", id);
        cfg_cpol = v.cpol; cfg_cpha = v.cpha; cfg_div = v.div;
        s_cpol = v.cpol; s_cpha = v.cpha; s_tx = v.slv; loop_en = v.loop;
        repeat (3) @(negedge clk);
        chk({t, "idle_sclk"}, 32'(spi_bus.sclk), 32'(v.cpol));
        chk({t, "ready_idle"}, 32'(tx_ready), 1);
        tx_data = v.tx; tx_valid = 1'b1;
        first_low = -1; last_low = -1; nrx = 0; rx_cyc = -1; rdy_cyc = -1;
        rx_val = '0; busy_mid = 1'b0;
        for (int cyc = 1; cyc <= v.exp_rdy_cyc + 50; cyc++) begin
            @(negedge clk);
            if (cyc == 1) tx_valid = 1'b0;
            if (v.chg && cyc == 10) begin
                cfg_cpol = v.chg_cpol; cfg_cpha = v.chg_cpha; cfg_div = v.chg_div;
            end
            if (cyc == 3) busy_mid = busy;
            if (!spi_bus.ss_n) begin
                if (first_low < 0) first_low = cyc;
                last_low = cyc;
            end
            if (rx_valid) begin nrx++; rx_cyc = cyc; rx_val = rx_data; end
            if (tx_ready) begin rdy_cyc = cyc; break; end
        end
        chk({t, "busy_mid"}, 32'(busy_mid), 1);
        chk({t, "ss_first"}, first_low, 1);
        chk({t, "ss_last"}, last_low, v.exp_rx_cyc - 1);
        chk({t, "rx_cycle"}, rx_cyc, v.exp_rx_cyc);
        chk({t, "rx_count"}, nrx, 1);
        chk({t, "rx_data"}, 32'(rx_val), 32'(v.exp_rx));
        chk({t, "ready_cycle"}, rdy_cyc, v.exp_rdy_cyc);
        chk({t, "rx_hold"}, 32'(rx_data), 32'(v.exp_rx));
        chk({t, "mosi_word"}, 32'(s_rx), 32'(v.tx));
        chk({t, "sclk_edges"}, s_edges, 16);
        chk({t, "busy_end"}, 32'(busy), 0);
    endtask

    vec_t vecs[8];
    logic [7:0] words[3];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //                cpol cpha div    tx     slv    loop chg ccpol ccpha cdiv   exp_rx rx_cyc rdy_cyc
        vecs[0] = '{1'b0, 1'b0, 8'h00, 8'hA5, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h3C, 19, 20};
        vecs[1] = '{1'b1, 1'b1, 8'h03, 8'h81, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hF0, 73, 77};
        vecs[2] = '{1'b0, 1'b1, 8'h01, 8'h5A, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h5A, 37, 39};
        vecs[3] = '{1'b1, 1'b0, 8'h00, 8'h5A, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h5A, 19, 20};
        vecs[4] = '{1'b0, 1'b0, 8'h01, 8'h96, 8'h69, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 8'h69, 37, 39};
        vecs[5] = '{1'b1, 1'b1, 8'h00, 8'h3C, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hC3, 19, 20};
        vecs[6] = '{1'b0, 1'b1, 8'hFF, 8'hE7, 8'h18, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h18, 4609, 4865};
        vecs[7] = '{1'b0, 1'b0, 8'h00, 8'hC3, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h5A, 19, 20};
        words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;

        // Reset values
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_tx_ready", 32'(tx_ready), 0);
        chk("rst_rx_valid", 32'(rx_valid), 0);
        chk("rst_rx_data", 32'(rx_data), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_sclk", 32'(spi_bus.sclk), 0);
        chk("rst_ss_n", 32'(spi_bus.ss_n), 1);
        chk("rst_mosi", 32'(spi_bus.mosi), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_tx_ready", 32'(tx_ready), 1);

        for (int i = 0; i < 7; i++) run_word(vecs[i], i);

        // Back-to-back: tx_valid held across three words, loopback mode 0
        begin
            int nacc, nrx, frames, gap;
            bit pend;
            logic pss;
            cfg_cpol = 1'b0; cfg_cpha = 1'b0; cfg_div = 8'h00;
            s_cpol = 1'b0; s_cpha = 1'b0; loop_en = 1'b1;
            repeat (3) @(negedge clk);
            nacc = 0; nrx = 0; frames = 0; gap = 0; pend = 1'b0; pss = 1'b1;
            tx_data = words[0]; tx_valid = 1'b1;
            for (int c = 0; c < 300 && nrx < 3; c++) begin
                if (pend) begin
                    pend = 1'b0;
                    if (nacc < 3) tx_data = words[nacc];
                    else tx_valid = 1'b0;
                end
                if (tx_valid && tx_ready) begin nacc++; pend = 1'b1; end
                @(negedge clk);
                if (rx_valid) begin
                    if (nrx < 3) chk($sformatf("b2b_rx%0d", nrx), 32'(rx_data), 32'(words[nrx]));
                    nrx++;
                end
                if (spi_bus.ss_n) gap++;
                if (pss && !spi_bus.ss_n) begin
                    // GAP (H=1) plus the IDLE cycle in which the next word is accepted
                    if (frames > 0) chk($sformatf("b2b_gap%0d", frames), gap, 2);
                    frames++;
                end
                if (!spi_bus.ss_n) gap = 0;
                pss = spi_bus.ss_n;
            end
            tx_valid = 1'b0;
            chk("b2b_frames", frames, 3);
            chk("b2b_rx_count", nrx, 3);
            chk("b2b_accepts", nacc, 3);
            repeat (4) @(negedge clk);
        end

        // Reset during XFER edge 7 (mode 1: sclk is high there)
        begin
            bit hit;
            int cnt;
            cfg_cpol = 1'b0; cfg_cpha = 1'b1; cfg_div = 8'h03;
            s_cpol = 1'b0; s_cpha = 1'b1; s_tx = 8'h00; loop_en = 1'b0;
            repeat (3) @(negedge clk);
            tx_data = 8'h81; tx_valid = 1'b1;
            @(negedge clk);
            tx_valid = 1'b0;
            hit = 1'b0;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                if (s_edges == 7) begin hit = 1'b1; break; end
            end
            chk("mid_edge7_reached", 32'(hit), 1);
            chk("mid_sclk_before", 32'(spi_bus.sclk), 1);
            rst_n = 1'b0;
            #1;
            chk("mid_ss_n", 32'(spi_bus.ss_n), 1);
            chk("mid_sclk", 32'(spi_bus.sclk), 0);
            chk("mid_mosi", 32'(spi_bus.mosi), 0);
            chk("mid_busy", 32'(busy), 0);
            chk("mid_tx_ready", 32'(tx_ready), 0);
            chk("mid_rx_data", 32'(rx_data), 0);
            @(negedge clk);
            rst_n = 1'b1;
            cnt = 0;
            for (int i = 0; i < 80; i++) begin
                @(negedge clk);
                if (rx_valid) cnt++;
            end
            chk("mid_no_rx", cnt, 0);
        end

        run_word(vecs[7], 7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
